// File: rtl/input_router.sv
// Routes synchronized external pins to one of NCPU ports.
// Switchovers blank every port to IDLE for GUARD+1 cycles.
module input_router #(
  parameter int               WIDTH = 8,
  parameter int               NCPU  = 2,
  parameter int               SEL_W = 1,
  parameter logic [WIDTH-1:0] IDLE  = '1,
  parameter int               GUARD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      ctr_io,
  input  logic [WIDTH-1:0]      input_pin,
  output logic [NCPU*WIDTH-1:0] input_to_cpu,
  output logic [SEL_W-1:0]      active_sel,
  output logic                  switching,
  output logic                  sel_err
);

  typedef enum logic {
    RUN,
    BLANK
  } state_t;

  localparam logic [SEL_W:0] NCPU_W = (SEL_W+1)'(NCPU);
  localparam logic [7:0] CNT_INIT = 8'(GUARD - 1);
  localparam logic [NCPU*WIDTH-1:0] ALL_IDLE = {NCPU{IDLE}};

  logic [WIDTH-1:0] pin_m;
  logic [WIDTH-1:0] pin_s;
  logic [SEL_W-1:0] sel_m;
  logic [SEL_W-1:0] sel_s;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] target;
  logic [7:0]       cnt;
  state_t           state;
  logic             sel_ok;

  assign sel_ok = {1'b0, sel_s} < NCPU_W;

  function automatic logic [NCPU*WIDTH-1:0] route(
    input logic [SEL_W-1:0] sel,
    input logic [WIDTH-1:0] pin
  );
    logic [NCPU*WIDTH-1:0] v;
    v = ALL_IDLE;
    for (int k = 0; k < NCPU; k++) begin
      if (sel == SEL_W'(k)) begin
        v[k*WIDTH +: WIDTH] = pin;
      end
    end
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      pin_m <= IDLE;
      pin_s <= IDLE;
      sel_m <= '0;
      sel_s <= '0;
    end else begin
      pin_m <= input_pin;
      pin_s <= pin_m;
      sel_m <= ctr_io;
      sel_s <= sel_m;
    end
  end

  // switching stays high through the final BLANK edge so it
  // covers the whole window in which the ports read IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      target       <= '0;
      active_sel   <= '0;
      cnt          <= '0;
      input_to_cpu <= ALL_IDLE;
      switching    <= 1'b0;
      sel_err      <= 1'b0;
      sel_q        <= '0;
    end else begin
      sel_q   <= sel_s;
      sel_err <= !sel_ok && (sel_s != sel_q);
      unique case (state)
        RUN: begin
          if (sel_ok && (sel_s != active_sel)) begin
            state        <= BLANK;
            target       <= sel_s;
            cnt          <= CNT_INIT;
            input_to_cpu <= ALL_IDLE;
            switching    <= 1'b1;
          end else begin
            input_to_cpu <= route(active_sel, pin_s);
            switching    <= 1'b0;
          end
        end
        BLANK: begin
          input_to_cpu <= ALL_IDLE;
          switching    <= 1'b1;
          if (sel_ok && (sel_s != target)) begin
            target <= sel_s;
            cnt    <= CNT_INIT;
          end else if (cnt == 8'd0) begin
            active_sel <= target;
            state      <= RUN;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_router.sv
// Randomized bench for input_router, two parameter sets,
// checked every cycle against a blanking-window model.
module tb_input_router;

  localparam int GUARD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ctr = 2'd0;
  logic [7:0]  pin = 8'hFF;

  logic [15:0] out_a;
  logic [0:0]  act_a;
  logic        sw_a;
  logic        err_a;
  logic [23:0] out_b;
  logic [1:0]  act_b;
  logic        sw_b;
  logic        err_b;

  int n_cmp = 0;
  int n_bad = 0;

  int          m_route [2];
  int          m_pend  [2];
  int          m_left  [2];
  int          m_prev  [2];
  int          sh_sel  [2][2];
  logic [7:0]  sh_pin  [2][2];
  logic [23:0] e_out   [2];
  int          e_act   [2];
  logic        e_sw    [2];
  logic        e_err   [2];

  always #5 clk = ~clk;

  input_router u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .ctr_io       (ctr[0]),
    .input_pin    (pin),
    .input_to_cpu (out_a),
    .active_sel   (act_a),
    .switching    (sw_a),
    .sel_err      (err_a)
  );

  input_router #(
    .NCPU  (3),
    .SEL_W (2)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .ctr_io       (ctr),
    .input_pin    (pin),
    .input_to_cpu (out_b),
    .active_sel   (act_b),
    .switching    (sw_b),
    .sel_err      (err_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // m_left counts the IDLE output edges still owed by a switchover
  task automatic model_step(input int id);
    int         n;
    int         s;
    logic [7:0] p;
    bit         ok;
    logic [23:0] e;
    n = (id == 0) ? 2 : 3;
    if (rst) begin
      m_route[id] = 0;
      m_pend[id]  = 0;
      m_left[id]  = 0;
      m_prev[id]  = 0;
      for (int i = 0; i < 2; i++) begin
        sh_sel[id][i] = 0;
        sh_pin[id][i] = 8'hFF;
      end
      e_out[id] = (id == 0) ? 24'h00FFFF : 24'hFFFFFF;
      e_act[id] = 0;
      e_sw[id]  = 1'b0;
      e_err[id] = 1'b0;
      return;
    end
    s = sh_sel[id][1];
    p = sh_pin[id][1];
    sh_sel[id][1] = sh_sel[id][0];
    sh_pin[id][1] = sh_pin[id][0];
    sh_sel[id][0] = (id == 0) ? int'(ctr[0]) : int'(ctr);
    sh_pin[id][0] = pin;
    ok = (s < n);
    e_err[id] = !ok && (s != m_prev[id]);
    m_prev[id] = s;
    if (ok && ((m_left[id] == 0 && s != m_route[id]) ||
               (m_left[id] > 0 && s != m_pend[id]))) begin
      m_pend[id] = s;
      m_left[id] = GUARD + 1;
    end
    e = 24'h0;
    for (int k = 0; k < n; k++) begin
      if (m_left[id] == 0 && k == m_route[id]) e[k*8 +: 8] = p;
      else e[k*8 +: 8] = 8'hFF;
    end
    e_out[id] = e;
    if (m_left[id] > 0) begin
      e_sw[id] = 1'b1;
      m_left[id]--;
      if (m_left[id] == 0) m_route[id] = m_pend[id];
    end else begin
      e_sw[id] = 1'b0;
    end
    e_act[id] = m_route[id];
  endtask

  function automatic int busy_slices(input logic [23:0] v,
                                     input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) begin
      if (v[k*8 +: 8] != 8'hFF) c++;
    end
    return c;
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    #1;
    check("out_a", {16'h0, out_a}, {8'h0, e_out[0]});
    check("act_a", {31'h0, act_a}, e_act[0]);
    check("sw_a", {31'h0, sw_a}, {31'h0, e_sw[0]});
    check("err_a", {31'h0, err_a}, {31'h0, e_err[0]});
    check("out_b", {8'h0, out_b}, {8'h0, e_out[1]});
    check("act_b", {30'h0, act_b}, e_act[1]);
    check("sw_b", {31'h0, sw_b}, {31'h0, e_sw[1]});
    check("err_b", {31'h0, err_b}, {31'h0, e_err[1]});
    check("one_a", busy_slices({8'h0, out_a}, 2) <= 1, 1);
    check("one_b", busy_slices(out_b, 3) <= 1, 1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    pin = 8'h5A;
    step(6);
    pin = 8'h3C;
    ctr = 2'd1;
    step(12);
    ctr = 2'd2;
    step(4);
    ctr = 2'd3;
    step(12);
    ctr = 2'd1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(8);
    for (int i = 0; i < 6000; i++) begin
      pin = 8'($urandom);
      if ($urandom_range(0, 15) == 0) ctr = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
